// File: rtl/rv_mem_resp_if.sv
// Core-side bus bundle for rv_mem_resp: instruction fetch (i_*) and load/store (d_*) ports.
// A request is accepted on a rising edge where re=1 and rdy=1. Data becomes valid on the first edge
// where rdy returns to 1 after the accept. Outside an access, rdy stays 1 and dr holds its last value.
interface rv_mem_resp_if;
    logic [31:0] i_adr;
    logic        i_re;
    logic [31:0] i_dr;
    logic        i_rdy;
    logic [31:0] d_adr;
    logic        d_re;
    logic [31:0] d_dw;
    logic [3:0]  d_we;
    logic [31:0] d_dr;
    logic        d_rdy;
    logic        i_busy;
    logic        d_busy;

    modport master (
        output i_adr, i_re, d_adr, d_re, d_dw, d_we,
        input  i_dr, i_rdy, d_dr, d_rdy, i_busy, d_busy
    );

    modport slave (
        input  i_adr, i_re, d_adr, d_re, d_dw, d_we,
        output i_dr, i_rdy, d_dr, d_rdy, i_busy, d_busy
    );
endinterface

// File: rtl/rv_mem_resp.sv
// Tightly-coupled program/data memory for the rv core. The memory is split into even-word and odd-word banks,
// so a halfword-aligned 32-bit fetch can be served in a single access.
module rv_mem_port_ctl #(
    parameter int unsigned WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        re,
    input  logic [31:0] rdata,
    output logic        accept,
    output logic        rdy,
    output logic [31:0] dr,
    output logic        busy
);
    typedef enum logic {ST_IDLE, ST_WAITING} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] dr_q, dr_d;

    // The RAM is read at the accept edge. The word is parked in buf until the last wait cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dr_d    = dr_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (re) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        dr_d = rdata;
                    end else begin
                        buf_d   = rdata;
                        cnt_d   = 3'(WAIT);
                        state_d = ST_WAITING;
                    end
                end
            end
            ST_WAITING: begin
                if (cnt_q == 3'd1) begin
                    dr_d    = buf_q;
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            buf_q   <= 32'd0;
            dr_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dr_q    <= dr_d;
        end
    end

    always_comb begin
        rdy  = (state_q == ST_IDLE);
        busy = (state_q == ST_WAITING);
        dr   = dr_q;
    end
endmodule

module rv_mem_resp #(
    parameter int unsigned AWIDTH = 14,
    parameter int unsigned I_WAIT = 0,
    parameter int unsigned D_WAIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    rv_mem_resp_if.slave bus
);
    localparam int unsigned ROWS = 1 << (AWIDTH - 1);

    logic [31:0] even_mem [ROWS];
    logic [31:0] odd_mem  [ROWS];

    logic [AWIDTH-1:0] i_w, i_w1, d_w;
    logic [AWIDTH-2:0] even_row, odd_row, d_row;
    logic [31:0]       even_rd, odd_rd, lo_word, hi_word;
    logic [31:0]       i_rdata, d_rdata;
    logic              i_accept, d_accept;

    // The fetch always needs one word from each bank: w and w+1 differ in bit 0.
    always_comb begin
        i_w      = bus.i_adr[AWIDTH+1:2];
        i_w1     = i_w + AWIDTH'(1);
        odd_row  = i_w[AWIDTH-1:1];
        even_row = i_w[0] ? i_w1[AWIDTH-1:1] : i_w[AWIDTH-1:1];
        even_rd  = even_mem[even_row];
        odd_rd   = odd_mem[odd_row];
        lo_word  = i_w[0] ? odd_rd : even_rd;
        hi_word  = i_w[0] ? even_rd : odd_rd;
        i_rdata  = bus.i_adr[1] ? {hi_word[15:0], lo_word[31:16]} : lo_word;

        d_w      = bus.d_adr[AWIDTH+1:2];
        d_row    = d_w[AWIDTH-1:1];
        d_rdata  = d_w[0] ? odd_mem[d_row] : even_mem[d_row];
    end

    rv_mem_port_ctl #(.WAIT(I_WAIT)) u_i_port (
        .clk    (clk),
        .reset  (reset),
        .re     (bus.i_re),
        .rdata  (i_rdata),
        .accept (i_accept),
        .rdy    (bus.i_rdy),
        .dr     (bus.i_dr),
        .busy   (bus.i_busy)
    );

    rv_mem_port_ctl #(.WAIT(D_WAIT)) u_d_port (
        .clk    (clk),
        .reset  (reset),
        .re     (bus.d_re),
        .rdata  (d_rdata),
        .accept (d_accept),
        .rdy    (bus.d_rdy),
        .dr     (bus.d_dr),
        .busy   (bus.d_busy)
    );

    // Non-blocking writes make any read at the same edge return the pre-write word.
    always_ff @(posedge clk) begin
        if (!reset && d_accept) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.d_we[n]) begin
                    if (d_w[0]) begin
                        odd_mem[d_row][8*n +: 8] <= bus.d_dw[8*n +: 8];
                    end else begin
                        even_mem[d_row][8*n +: 8] <= bus.d_dw[8*n +: 8];
                    end
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.i_adr[31:AWIDTH+2], bus.i_adr[0],
                           bus.d_adr[31:AWIDTH+2], bus.d_adr[1:0], i_accept};
endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp with three instances: no wait states, D_WAIT=2, and D_WAIT=3 (reset mid-wait).
module tb_rv_mem_resp;
    logic clk;
    logic rst;
    logic rst3;
    int   errors = 0;
    int   checks = 0;

    rv_mem_resp_if bus0 ();
    rv_mem_resp_if bus2 ();
    rv_mem_resp_if bus3 ();

    rv_mem_resp #(.AWIDTH(6), .I_WAIT(0), .D_WAIT(0)) u_dut0 (.clk(clk), .reset(rst),  .bus(bus0));
    rv_mem_resp #(.AWIDTH(6), .I_WAIT(0), .D_WAIT(2)) u_dut2 (.clk(clk), .reset(rst),  .bus(bus2));
    rv_mem_resp #(.AWIDTH(6), .I_WAIT(0), .D_WAIT(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle write on the no-wait instance; leaves the d port idle afterwards.
    task automatic wr0(input logic [31:0] adr, input logic [3:0] we, input logic [31:0] dw);
        bus0.d_adr = adr;
        bus0.d_we  = we;
        bus0.d_dw  = dw;
        bus0.d_re  = 1'b1;
        step();
        bus0.d_re  = 1'b0;
        bus0.d_we  = 4'd0;
    endtask

    task automatic fetch0(input logic [31:0] adr);
        bus0.i_adr = adr;
        bus0.i_re  = 1'b1;
        step();
        bus0.i_re  = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        rst3 = 1'b1;
        bus0.i_adr = '0; bus0.i_re = 1'b0; bus0.d_adr = '0; bus0.d_re = 1'b0; bus0.d_dw = '0; bus0.d_we = '0;
        bus2.i_adr = '0; bus2.i_re = 1'b0; bus2.d_adr = '0; bus2.d_re = 1'b0; bus2.d_dw = '0; bus2.d_we = '0;
        bus3.i_adr = '0; bus3.i_re = 1'b0; bus3.d_adr = '0; bus3.d_re = 1'b0; bus3.d_dw = '0; bus3.d_we = '0;
        step();
        step();
        rst  = 1'b0;
        rst3 = 1'b0;

        chk("rst_i_rdy", {31'd0, bus0.i_rdy}, 32'd1);
        chk("rst_d_rdy", {31'd0, bus0.d_rdy}, 32'd1);
        chk("rst_i_dr", bus0.i_dr, 32'd0);
        chk("rst_d_dr", bus0.d_dr, 32'd0);
        chk("rst_d_busy2", {31'd0, bus2.d_busy}, 32'd0);

        // Preload through the data port
        wr0(32'h00, 4'hF, 32'h0000_0013);
        wr0(32'h04, 4'hF, 32'h1122_3344);
        wr0(32'h08, 4'hF, 32'hAAAA_8082);
        wr0(32'h0C, 4'hF, 32'h0001_0537);
        wr0(32'h10, 4'hF, 32'h1122_3344);
        wr0(32'hFC, 4'hF, 32'hCAFE_F00D);
        chk("wr_d_rdy", {31'd0, bus0.d_rdy}, 32'd1);

        // Back-to-back single-cycle fetches
        bus0.i_re  = 1'b1;
        bus0.i_adr = 32'h0;
        step();
        chk("fetch_0", bus0.i_dr, 32'h0000_0013);
        chk("fetch_0_rdy", {31'd0, bus0.i_rdy}, 32'd1);
        bus0.i_adr = 32'h4;
        step();
        chk("fetch_4", bus0.i_dr, 32'h1122_3344);
        chk("fetch_4_rdy", {31'd0, bus0.i_rdy}, 32'd1);
        bus0.i_re = 1'b0;

        fetch0(32'h0A);
        chk("fetch_straddle", bus0.i_dr, 32'h0537_AAAA);
        fetch0(32'hFE);
        chk("fetch_top_wrap", bus0.i_dr, 32'h0013_CAFE);
        fetch0(32'h104);
        chk("fetch_alias", bus0.i_dr, 32'h1122_3344);
        fetch0(32'h0B);
        chk("fetch_bit0_ign", bus0.i_dr, 32'h0537_AAAA);
        bus0.i_adr = 32'h0;
        step();
        chk("idle_hold_dr", bus0.i_dr, 32'h0537_AAAA);
        chk("idle_hold_rdy", {31'd0, bus0.i_rdy}, 32'd1);

        // Byte-lane write, then read back
        wr0(32'h10, 4'b0100, 32'h00AB_0000);
        chk("bytewr_preword", bus0.d_dr, 32'h1122_3344);
        bus0.d_adr = 32'h10;
        bus0.d_re  = 1'b1;
        step();
        bus0.d_re  = 1'b0;
        chk("bytewr_read", bus0.d_dr, 32'h11AB_3344);
        bus0.d_adr = 32'h13;
        bus0.d_re  = 1'b1;
        step();
        bus0.d_re  = 1'b0;
        chk("read_lowbits_ign", bus0.d_dr, 32'h11AB_3344);

        // Same-cycle fetch and write collisions
        wr0(32'h20, 4'hF, 32'h1234_5678);
        bus0.i_adr = 32'h20;
        bus0.i_re  = 1'b1;
        wr0(32'h20, 4'hF, 32'hDEAD_BEEF);
        bus0.i_re  = 1'b0;
        chk("coll_fetch_old", bus0.i_dr, 32'h1234_5678);
        chk("coll_d_old", bus0.d_dr, 32'h1234_5678);
        fetch0(32'h20);
        chk("coll_fetch_new", bus0.i_dr, 32'hDEAD_BEEF);
        wr0(32'h1C, 4'hF, 32'h5555_6666);
        bus0.i_adr = 32'h1E;
        bus0.i_re  = 1'b1;
        wr0(32'h20, 4'hF, 32'h0102_0304);
        bus0.i_re  = 1'b0;
        chk("coll_straddle_old", bus0.i_dr, 32'hBEEF_5555);
        fetch0(32'h1E);
        chk("coll_straddle_new", bus0.i_dr, 32'h0304_5555);

        // D_WAIT=2 instance: preload two words, each write taking three cycles
        bus2.d_adr = 32'h14; bus2.d_we = 4'hF; bus2.d_dw = 32'h5A5A_0005; bus2.d_re = 1'b1;
        step();
        bus2.d_re = 1'b0; bus2.d_we = 4'h0;
        step();
        step();
        bus2.d_adr = 32'h18; bus2.d_we = 4'hF; bus2.d_dw = 32'h6666_0006; bus2.d_re = 1'b1;
        step();
        bus2.d_re = 1'b0; bus2.d_we = 4'h0;
        step();
        step();
        chk("w2_idle_after_wr", {31'd0, bus2.d_rdy}, 32'd1);

        bus2.d_adr = 32'h14;
        bus2.d_re  = 1'b1;
        bus2.i_adr = 32'h18;
        bus2.i_re  = 1'b1;
        step();
        bus2.i_re  = 1'b0;
        chk("w2_rdy_t1", {31'd0, bus2.d_rdy}, 32'd0);
        chk("w2_busy_t1", {31'd0, bus2.d_busy}, 32'd1);
        chk("w2_i_rdy", {31'd0, bus2.i_rdy}, 32'd1);
        chk("w2_i_dr", bus2.i_dr, 32'h6666_0006);
        bus2.d_adr = 32'h18;
        step();
        chk("w2_rdy_t2", {31'd0, bus2.d_rdy}, 32'd0);
        bus2.d_re = 1'b0;
        step();
        chk("w2_rdy_t3", {31'd0, bus2.d_rdy}, 32'd1);
        chk("w2_data_t3", bus2.d_dr, 32'h5A5A_0005);
        step();
        chk("w2_hold", bus2.d_dr, 32'h5A5A_0005);

        // D_WAIT=3 instance: write, start a read, reset mid-wait, read again
        bus3.d_adr = 32'h04; bus3.d_we = 4'hF; bus3.d_dw = 32'h7777_0001; bus3.d_re = 1'b1;
        step();
        bus3.d_re = 1'b0; bus3.d_we = 4'h0;
        step();
        step();
        step();
        bus3.d_re = 1'b1;
        step();
        bus3.d_re = 1'b0;
        step();
        chk("w3_waiting", {31'd0, bus3.d_rdy}, 32'd0);
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        chk("w3_rst_rdy", {31'd0, bus3.d_rdy}, 32'd1);
        chk("w3_rst_dr", bus3.d_dr, 32'd0);
        chk("w3_rst_busy", {31'd0, bus3.d_busy}, 32'd0);
        bus3.d_re = 1'b1;
        step();
        bus3.d_re = 1'b0;
        step();
        step();
        chk("w3_rdy_t3", {31'd0, bus3.d_rdy}, 32'd0);
        chk("w3_dr_hold", bus3.d_dr, 32'd0);
        step();
        chk("w3_rdy_done", {31'd0, bus3.d_rdy}, 32'd1);
        chk("w3_data", bus3.d_dr, 32'h7777_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
